// File: rtl/acc_req_arbiter_if.sv
// Bundle of dispatcher-side and accelerator-side request/response signals for acc_req_arbiter.
// master: dispatchers + accelerator environment, slave: the arbiter.
interface acc_req_arbiter_if #(
  parameter int unsigned NrReq = 2
);
  typedef struct packed {
    logic [31:0] insn;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        req_valid;
    logic        resp_ready;
    logic        store_pending;
    logic        acc_cons_en;
    logic        inval_ready;
  } accelerator_req_t;

  typedef struct packed {
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] result;
    logic [4:0]  trans_id;
    logic        error;
    logic        fflags_valid;
    logic [4:0]  fflags;
    logic        store_pending;
    logic        load_complete;
    logic        store_complete;
    logic        inval_valid;
    logic [31:0] inval_addr;
  } accelerator_resp_t;

  accelerator_req_t  [NrReq-1:0] req_i;
  accelerator_resp_t [NrReq-1:0] resp_o;
  accelerator_req_t              acc_req_o;
  accelerator_resp_t             acc_resp_i;

  modport master (output req_i, acc_resp_i, input resp_o, acc_req_o);
  modport slave  (input req_i, acc_resp_i, output resp_o, acc_req_o);
endinterface

// File: rtl/acc_req_arbiter.sv
// Shares one accelerator port among NrReq dispatchers: round-robin locked grant, in-order response steering.
// Define ACC_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins) instead of round-robin.
module acc_req_arbiter #(
  parameter int unsigned NrReq          = 2,
  parameter int unsigned MaxOutstanding = 4
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  acc_req_arbiter_if.slave                      bus,
  output logic                                  busy_o,
  output logic [$clog2(MaxOutstanding+1)-1:0]   outstanding_o
);
  localparam int unsigned IdxW = (NrReq > 1) ? $clog2(NrReq) : 1;
  localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

  typedef enum logic {IDLE, LOCKED} state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IdxW-1:0] grant_q, grant_d;
  logic [IdxW-1:0] gnt_idx;
  logic            gnt_vld;
  logic            hs, push, pop, empty, can_grant;
  logic [IdxW-1:0] fifo_mem [MaxOutstanding];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;
  logic [IdxW-1:0] src;
  int unsigned     k;

  assign empty     = (count_q == '0);
  assign can_grant = (count_q < CntW'(MaxOutstanding));
  assign src       = fifo_mem[rd_ptr_q];

  // Eligibility uses the registered count, so a same-cycle pop never frees a slot for a grant.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    k       = 0;
    if (state_q == LOCKED) begin
      gnt_vld = 1'b1;
      gnt_idx = grant_q;
    end else if (can_grant) begin
      for (int unsigned i = 0; i < NrReq; i++) begin
        k = (32'(rr_ptr_q) + i) % NrReq;
        if (!gnt_vld && bus.req_i[IdxW'(k)].req_valid) begin
          gnt_vld = 1'b1;
          gnt_idx = IdxW'(k);
        end
      end
    end
  end

  assign hs   = gnt_vld && bus.req_i[gnt_idx].req_valid && bus.acc_resp_i.req_ready;
  assign push = hs;
  assign pop  = bus.acc_resp_i.resp_valid && !empty && bus.req_i[src].resp_ready;

  always_comb begin
    bus.acc_req_o = '0;
    if (gnt_vld) bus.acc_req_o = bus.req_i[gnt_idx];
    bus.acc_req_o.resp_ready    = bus.req_i[src].resp_ready;
    bus.acc_req_o.store_pending = 1'b0;
    bus.acc_req_o.acc_cons_en   = 1'b0;
    bus.acc_req_o.inval_ready   = 1'b0;
    for (int unsigned i = 0; i < NrReq; i++) begin
      bus.acc_req_o.store_pending |= bus.req_i[i].store_pending;
      bus.acc_req_o.acc_cons_en   |= bus.req_i[i].acc_cons_en;
      bus.acc_req_o.inval_ready   |= bus.req_i[i].inval_ready;
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NrReq; i++) begin
      bus.resp_o[i]            = bus.acc_resp_i;
      bus.resp_o[i].req_ready  = hs && (gnt_idx == IdxW'(i));
      bus.resp_o[i].resp_valid = bus.acc_resp_i.resp_valid && !empty && (src == IdxW'(i));
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      IDLE: begin
        if (gnt_vld && !hs) begin
          state_d = LOCKED;
          grant_d = gnt_idx;
        end
      end
      LOCKED: begin
        if (hs) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
`ifdef ACC_ARB_FIXED_PRIO_EN
    rr_ptr_d = '0;
`else
    if (hs) rr_ptr_d = (gnt_idx == IdxW'(NrReq - 1)) ? '0 : gnt_idx + 1'b1;
`endif
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      if (push) wr_ptr_q <= (wr_ptr_q == PtrW'(MaxOutstanding - 1)) ? '0 : wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= (rd_ptr_q == PtrW'(MaxOutstanding - 1)) ? '0 : rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Source storage carries no reset; validity is tracked by the pointers and count.
  always_ff @(posedge clk_i) begin
    if (push) fifo_mem[wr_ptr_q] <= gnt_idx;
  end

  assign busy_o        = !empty || (state_q == LOCKED);
  assign outstanding_o = count_q;

  always @(posedge clk_i) begin
    if (rst_ni) begin
      assert (!(bus.acc_resp_i.resp_valid && empty))
        else $error("[acc_req_arbiter] Orphan response.");
      assert (!(state_q == LOCKED && !bus.req_i[grant_q].req_valid))
        else $error("[acc_req_arbiter] Requester dropped valid while locked.");
    end
  end
endmodule

// File: tb/tb_acc_req_arbiter.sv
// Directed bench for acc_req_arbiter: grant order, locking, response steering, back-pressure, reset.
module tb_acc_req_arbiter;
  localparam int unsigned NR   = 2;
  localparam int unsigned MAXO = 4;
`ifdef ACC_ARB_FIXED_PRIO_EN
  localparam bit FixedPrio = 1'b1;
`else
  localparam bit FixedPrio = 1'b0;
`endif

  logic        clk_i  = 1'b0;
  logic        rst_ni = 1'b0;
  logic        busy_o;
  logic [2:0]  outstanding_o;
  int          checks = 0;
  int          errors = 0;
  int          src_q[$];
  logic [31:0] rv = 32'h5500;

  acc_req_arbiter_if #(.NrReq(NR)) bus ();

  acc_req_arbiter #(.NrReq(NR), .MaxOutstanding(MAXO)) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .bus           (bus.slave),
    .busy_o        (busy_o),
    .outstanding_o (outstanding_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic grant_step(input string tag, input int e, input logic acc);
    #1;
    check({tag, "_vld"}, 32'(bus.acc_req_o.req_valid), 32'd1);
    check({tag, "_insn"}, bus.acc_req_o.insn, 32'hA000_0000 + 32'(e));
    for (int i = 0; i < NR; i++)
      check({tag, "_rdy"}, 32'(bus.resp_o[i].req_ready), 32'(acc && (i == e)));
    if (acc) src_q.push_back(e);
    tick();
    check({tag, "_cnt"}, 32'(outstanding_o), 32'(src_q.size()));
  endtask

  task automatic resp_step(input string tag, input logic rdy0, input logic rdy1);
    int         src;
    logic [1:0] rdy;
    rdy = {rdy1, rdy0};
    src = src_q[0];
    rv  = rv + 32'h11;
    bus.acc_resp_i.resp_valid = 1'b1;
    bus.acc_resp_i.result     = rv;
    bus.req_i[0].resp_ready   = rdy0;
    bus.req_i[1].resp_ready   = rdy1;
    #1;
    check({tag, "_noreq"}, 32'(bus.acc_req_o.req_valid), 32'd0);
    check({tag, "_rrdy"}, 32'(bus.acc_req_o.resp_ready), 32'(rdy[src]));
    for (int i = 0; i < NR; i++) begin
      check({tag, "_rv"}, 32'(bus.resp_o[i].resp_valid), 32'(i == src));
      check({tag, "_res"}, bus.resp_o[i].result, rv);
    end
    if (rdy[src]) void'(src_q.pop_front());
    tick();
    bus.acc_resp_i.resp_valid = 1'b0;
    bus.req_i[0].resp_ready   = 1'b0;
    bus.req_i[1].resp_ready   = 1'b0;
    check({tag, "_cnt"}, 32'(outstanding_o), 32'(src_q.size()));
  endtask

  initial begin
    bus.req_i      = '0;
    bus.acc_resp_i = '0;
    for (int i = 0; i < NR; i++) bus.req_i[i].insn = 32'hA000_0000 + 32'(i);
    repeat (2) @(posedge clk_i);
    #1;
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_cnt", 32'(outstanding_o), 32'd0);
    check("rst_req_vld", 32'(bus.acc_req_o.req_valid), 32'd0);
    for (int i = 0; i < NR; i++) begin
      check("rst_resp_vld", 32'(bus.resp_o[i].resp_valid), 32'd0);
      check("rst_req_rdy", 32'(bus.resp_o[i].req_ready), 32'd0);
    end
    rst_ni = 1'b1;
    tick();

    // Round-robin sharing until full, then a pop without a same-cycle grant.
    bus.acc_resp_i.req_ready = 1'b1;
    bus.req_i[0].req_valid   = 1'b1;
    bus.req_i[1].req_valid   = 1'b1;
    for (int i = 0; i < 4; i++) grant_step("rr", FixedPrio ? 0 : i % 2, 1'b1);
    check("full_cnt", 32'(outstanding_o), 32'd4);
    check("full_busy", 32'(busy_o), 32'd1);
    check("full_no_grant", 32'(bus.acc_req_o.req_valid), 32'd0);
    resp_step("full_pop", 1'b1, 1'b1);
    grant_step("refill", 0, 1'b1);
    bus.req_i[0].req_valid = 1'b0;
    bus.req_i[1].req_valid = 1'b0;
    for (int i = 0; i < 4; i++) resp_step("drain", 1'b1, 1'b1);
    check("drain_busy", 32'(busy_o), 32'd0);

    // Grant lock while the accelerator is not ready.
    bus.acc_resp_i.req_ready = 1'b0;
    bus.req_i[0].req_valid   = 1'b1;
    grant_step("lock_c0", 0, 1'b0);
    check("lock_busy", 32'(busy_o), 32'd1);
    bus.req_i[1].req_valid     = 1'b1;
    bus.req_i[1].store_pending = 1'b1;
    #1;
    check("or_store_pending", 32'(bus.acc_req_o.store_pending), 32'd1);
    grant_step("lock_c1", 0, 1'b0);
    bus.req_i[1].store_pending = 1'b0;
    grant_step("lock_c2", 0, 1'b0);
    bus.acc_resp_i.req_ready = 1'b1;
    grant_step("lock_c3", 0, 1'b1);
    bus.req_i[0].req_valid = 1'b0;
    grant_step("lock_next", 1, 1'b1);
    bus.req_i[1].req_valid = 1'b0;

    // Back-pressure from head source 0, then pop both.
    resp_step("bp_hold0", 1'b0, 1'b1);
    resp_step("bp_hold1", 1'b0, 1'b1);
    resp_step("bp_pop", 1'b1, 1'b1);
    resp_step("bp_pop1", 1'b1, 1'b1);

    // Response steering for sources 1, 0, 1.
    bus.req_i[1].req_valid = 1'b1;
    grant_step("st_a", 1, 1'b1);
    bus.req_i[1].req_valid = 1'b0;
    bus.req_i[0].req_valid = 1'b1;
    grant_step("st_b", 0, 1'b1);
    bus.req_i[0].req_valid = 1'b0;
    bus.req_i[1].req_valid = 1'b1;
    grant_step("st_c", 1, 1'b1);
    bus.req_i[1].req_valid = 1'b0;
    for (int i = 0; i < 3; i++) resp_step("steer", 1'b1, 1'b1);

    // Simultaneous push and pop at count 2.
    bus.req_i[0].req_valid = 1'b1;
    grant_step("sim_a", 0, 1'b1);
    bus.req_i[0].req_valid = 1'b0;
    bus.req_i[1].req_valid = 1'b1;
    grant_step("sim_b", 1, 1'b1);
    bus.req_i[1].req_valid    = 1'b0;
    bus.req_i[0].req_valid    = 1'b1;
    bus.acc_resp_i.resp_valid = 1'b1;
    bus.req_i[0].resp_ready   = 1'b1;
    bus.req_i[1].resp_ready   = 1'b1;
    #1;
    check("sim_insn", bus.acc_req_o.insn, 32'hA000_0000);
    check("sim_req_rdy", 32'(bus.resp_o[0].req_ready), 32'd1);
    check("sim_resp_vld", 32'(bus.resp_o[0].resp_valid), 32'd1);
    void'(src_q.pop_front());
    src_q.push_back(0);
    tick();
    bus.acc_resp_i.resp_valid = 1'b0;
    bus.req_i[0].req_valid    = 1'b0;
    bus.req_i[0].resp_ready   = 1'b0;
    bus.req_i[1].resp_ready   = 1'b0;
    check("sim_cnt", 32'(outstanding_o), 32'd2);
    resp_step("sim_head", 1'b0, 1'b0);

    // Reset in the middle of a locked grant.
    bus.acc_resp_i.req_ready = 1'b0;
    bus.req_i[0].req_valid   = 1'b1;
    grant_step("pre_rst", 0, 1'b0);
    check("pre_rst_busy", 32'(busy_o), 32'd1);
    #2;
    rst_ni = 1'b0;
    #1;
    check("rst_async_busy", 32'(busy_o), 32'd0);
    check("rst_async_cnt", 32'(outstanding_o), 32'd0);
    bus.req_i[0].req_valid = 1'b0;
    src_q.delete();
    tick();
    rst_ni = 1'b1;
    tick();
    check("post_rst_busy", 32'(busy_o), 32'd0);
    check("post_rst_cnt", 32'(outstanding_o), 32'd0);
    check("post_rst_vld", 32'(bus.acc_req_o.req_valid), 32'd0);
    bus.acc_resp_i.req_ready = 1'b1;
    bus.req_i[0].req_valid   = 1'b1;
    bus.req_i[1].req_valid   = 1'b1;
    grant_step("post_rst_rr", 0, 1'b1);
    grant_step("post_rst_rr2", FixedPrio ? 0 : 1, 1'b1);
    bus.req_i[0].req_valid = 1'b0;
    bus.req_i[1].req_valid = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
